// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with registered read data and a one-cycle valid strobe.
// Occupancy count, threshold flags and sticky overflow/underflow flags.
module sync_fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags are pure decodes of the registered count.
    always_comb begin
        full         = (count == CNT_W'(FIFO_DEPTH));
        empty        = (count == '0);
        almost_full  = (count >= CNT_W'(AF_THRESH));
        almost_empty = (count <= CNT_W'(AE_THRESH));
        wr_acc       = wr_en && !full;
        rd_acc       = rd_en && !empty;
    end

    // Storage array is not reset; entries are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers advance only on accepted accesses and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Occupancy: a simultaneous read and write leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered read port; dout holds between reads, valid pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= rd_acc;
            if (rd_acc) begin
                dout <= mem[rd_ptr];
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
